// File: rtl/board_referee.sv
// rtl/board_referee.sv - tic-tac-toe board owner: validates one move at a time, commits it, then scans the 8 win lines.
module board_referee #(
  parameter int NCELLS = 9,
  parameter int ADDRW  = 4
) (
  input  logic                ph1,
  input  logic                reset,
  input  logic                newGame,
  input  logic                moveValid,
  input  logic [ADDRW-1:0]    moveAddr,
  input  logic [1:0]          movePlayer,
  output logic                moveReady,
  output logic                moveAccept,
  output logic                moveReject,
  output logic [2*NCELLS-1:0] gBoard,
  output logic                gameIsDone,
  output logic [1:0]          winner
);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_WRITE, S_SCAN, S_DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDRW-1:0]    r_addr;
  logic [1:0]          r_player;
  logic [2*NCELLS-1:0] r_board;
  logic [3:0]          r_count;
  logic [2:0]          r_line;
  logic [1:0]          r_winner;
  logic                r_accept;
  logic                r_reject;

  logic [1:0]          w_target;
  logic                w_ok;
  logic [1:0]          w_c0, w_c1, w_c2;
  logic                w_match;

  always_comb begin
    w_target = 2'b00;
    for (int i = 0; i < NCELLS; i++) begin
      if (r_addr == ADDRW'(i)) w_target = r_board[2*i +: 2];
    end
  end

  assign w_ok = (r_addr < ADDRW'(NCELLS)) && (w_target == 2'b00) &&
                ((r_player == 2'b11) || (r_player == 2'b10));

  // Win-line table: rows, columns, then the two diagonals.
  always_comb begin
    w_c0 = 2'b00;
    w_c1 = 2'b00;
    w_c2 = 2'b00;
    case (r_line)
      3'd0:    begin w_c0 = r_board[1:0]; w_c1 = r_board[3:2];   w_c2 = r_board[5:4];   end
      3'd1:    begin w_c0 = r_board[7:6]; w_c1 = r_board[9:8];   w_c2 = r_board[11:10]; end
      3'd2:    begin w_c0 = r_board[13:12]; w_c1 = r_board[15:14]; w_c2 = r_board[17:16]; end
      3'd3:    begin w_c0 = r_board[1:0]; w_c1 = r_board[7:6];   w_c2 = r_board[13:12]; end
      3'd4:    begin w_c0 = r_board[3:2]; w_c1 = r_board[9:8];   w_c2 = r_board[15:14]; end
      3'd5:    begin w_c0 = r_board[5:4]; w_c1 = r_board[11:10]; w_c2 = r_board[17:16]; end
      3'd6:    begin w_c0 = r_board[1:0]; w_c1 = r_board[9:8];   w_c2 = r_board[17:16]; end
      default: begin w_c0 = r_board[5:4]; w_c1 = r_board[9:8];   w_c2 = r_board[13:12]; end
    endcase
  end

  assign w_match = (w_c0 != 2'b00) && (w_c0 == w_c1) && (w_c1 == w_c2);

  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (moveValid) w_next = S_CHECK;
      S_CHECK: w_next = w_ok ? S_WRITE : S_IDLE;
      S_WRITE: w_next = S_SCAN;
      S_SCAN: begin
        if (w_match)                w_next = S_DONE;
        else if (r_line == 3'd7)    w_next = (r_count == 4'd9) ? S_DONE : S_IDLE;
      end
      S_DONE:  w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
    if (newGame) w_next = S_IDLE;
  end

  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      r_addr   <= '0;
      r_player <= 2'b00;
      r_board  <= '0;
      r_count  <= 4'd0;
      r_line   <= 3'd0;
      r_winner <= 2'b00;
      r_accept <= 1'b0;
      r_reject <= 1'b0;
    end else begin
      r_accept <= 1'b0;
      r_reject <= 1'b0;
      if (newGame) begin
        r_board  <= '0;
        r_count  <= 4'd0;
        r_line   <= 3'd0;
        r_winner <= 2'b00;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (moveValid) begin
              r_addr   <= moveAddr;
              r_player <= movePlayer;
            end
          end
          S_CHECK: begin
            r_accept <= w_ok;
            r_reject <= !w_ok;
          end
          S_WRITE: begin
            for (int i = 0; i < NCELLS; i++) begin
              if (r_addr == ADDRW'(i)) r_board[2*i +: 2] <= r_player;
            end
            if (r_count != 4'd9) r_count <= r_count + 4'd1;
            r_line <= 3'd0;
          end
          S_SCAN: begin
            if (w_match)             r_winner <= w_c0;
            else if (r_line == 3'd7) begin
              if (r_count == 4'd9)   r_winner <= 2'b01;
            end else                 r_line <= r_line + 3'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign moveReady  = (r_state == S_IDLE);
  assign moveAccept = r_accept;
  assign moveReject = r_reject;
  assign gBoard     = r_board;
  assign gameIsDone = (r_state == S_DONE);
  assign winner     = r_winner;

endmodule

// File: tb/tb_board_referee.sv
// tb/tb_board_referee.sv - directed self-checking bench for board_referee.
module tb_board_referee;

  logic        ph1;
  logic        reset;
  logic        newGame;
  logic        moveValid;
  logic [3:0]  moveAddr;
  logic [1:0]  movePlayer;
  logic        moveReady;
  logic        moveAccept;
  logic        moveReject;
  logic [17:0] gBoard;
  logic        gameIsDone;
  logic [1:0]  winner;

  int n_pass  = 0;
  int n_total = 0;

  board_referee #(.NCELLS(9), .ADDRW(4)) dut (
    .ph1(ph1), .reset(reset), .newGame(newGame), .moveValid(moveValid),
    .moveAddr(moveAddr), .movePlayer(movePlayer), .moveReady(moveReady),
    .moveAccept(moveAccept), .moveReject(moveReject), .gBoard(gBoard),
    .gameIsDone(gameIsDone), .winner(winner)
  );

  initial ph1 = 1'b0;
  always #5 ph1 = ~ph1;

  task automatic step();
    @(posedge ph1);
    #1;
  endtask

  task automatic pulse_new_game();
    newGame = 1'b1;
    step();
    newGame = 1'b0;
  endtask

  // Drives one request; reports the cycle of each pulse and the cycles until ready/done.
  task automatic do_move(input logic [3:0] addr, input logic [1:0] player,
                         output int acc_cyc, output int rej_cyc, output int cycles);
    acc_cyc = 0;
    rej_cyc = 0;
    moveValid = 1'b1;
    moveAddr = addr;
    movePlayer = player;
    step();
    moveValid = 1'b0;
    cycles = 1;
    for (int k = 0; k < 30; k++) begin
      step();
      cycles++;
      if (moveAccept) acc_cyc = cycles;
      if (moveReject) rej_cyc = cycles;
      if (moveReady || gameIsDone) break;
    end
    if (!(moveReady || gameIsDone)) cycles = 99;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge ph1);
    #1;
    n_total++; if (moveReady !== 1'b1) $display("FAIL reset_ready got %b want 1", moveReady); else n_pass++;
    n_total++; if (gBoard !== 18'd0) $display("FAIL reset_board got %h want 0", gBoard); else n_pass++;
    n_total++; if ({moveAccept, moveReject, gameIsDone, winner} !== 5'b0) $display("FAIL reset_flags got %b want 00000", {moveAccept, moveReject, gameIsDone, winner}); else n_pass++;
    reset = 1'b0;
    step();
  endtask

  task automatic test_first_move();
    int a, r, c;
    logic [17:0] exp_b;
    exp_b = '0;
    exp_b[9:8] = 2'b11;
    do_move(4'd4, 2'b11, a, r, c);
    n_total++; if (a !== 2) $display("FAIL first_accept_cycle got %0d want 2", a); else n_pass++;
    n_total++; if (r !== 0) $display("FAIL first_no_reject got %0d want 0", r); else n_pass++;
    n_total++; if (c !== 11) $display("FAIL first_ready_cycles got %0d want 11", c); else n_pass++;
    n_total++; if (gBoard !== exp_b) $display("FAIL first_board got %h want %h", gBoard, exp_b); else n_pass++;
    n_total++; if ({gameIsDone, winner} !== 3'b000) $display("FAIL first_result got %b want 000", {gameIsDone, winner}); else n_pass++;
  endtask

  task automatic test_rejects();
    int a, r, c;
    logic [17:0] exp_b;
    exp_b = '0;
    exp_b[9:8] = 2'b11;
    do_move(4'd4, 2'b10, a, r, c);
    n_total++; if (r !== 2) $display("FAIL occupied_reject_cycle got %0d want 2", r); else n_pass++;
    n_total++; if (a !== 0 || c !== 2) $display("FAIL occupied_no_scan got acc=%0d cyc=%0d want 0/2", a, c); else n_pass++;
    do_move(4'd9, 2'b11, a, r, c);
    n_total++; if (r !== 2 || a !== 0) $display("FAIL addr9_reject got rej=%0d acc=%0d want 2/0", r, a); else n_pass++;
    do_move(4'd0, 2'b01, a, r, c);
    n_total++; if (r !== 2 || a !== 0) $display("FAIL player01_reject got rej=%0d acc=%0d want 2/0", r, a); else n_pass++;
    do_move(4'd0, 2'b00, a, r, c);
    n_total++; if (r !== 2 || a !== 0) $display("FAIL player00_reject got rej=%0d acc=%0d want 2/0", r, a); else n_pass++;
    n_total++; if (gBoard !== exp_b) $display("FAIL reject_board got %h want %h", gBoard, exp_b); else n_pass++;
  endtask

  task automatic test_row_win();
    int a, r, c;
    logic [17:0] exp_b;
    pulse_new_game();
    n_total++; if (gBoard !== 18'd0) $display("FAIL newgame_board got %h want 0", gBoard); else n_pass++;
    do_move(4'd0, 2'b11, a, r, c);
    do_move(4'd3, 2'b10, a, r, c);
    do_move(4'd1, 2'b11, a, r, c);
    do_move(4'd4, 2'b10, a, r, c);
    n_total++; if (c !== 11 || gameIsDone !== 1'b0) $display("FAIL row_premature got cyc=%0d done=%b want 11/0", c, gameIsDone); else n_pass++;
    do_move(4'd2, 2'b11, a, r, c);
    exp_b = '0;
    exp_b[1:0] = 2'b11; exp_b[3:2] = 2'b11; exp_b[5:4] = 2'b11;
    exp_b[7:6] = 2'b10; exp_b[9:8] = 2'b10;
    n_total++; if (c !== 4) $display("FAIL row_win_latency got %0d want 4", c); else n_pass++;
    n_total++; if ({gameIsDone, winner} !== 3'b111) $display("FAIL row_win_result got %b want 111", {gameIsDone, winner}); else n_pass++;
    n_total++; if (gBoard !== exp_b) $display("FAIL row_board got %h want %h", gBoard, exp_b); else n_pass++;
    moveValid = 1'b1; moveAddr = 4'd5; movePlayer = 2'b10;
    a = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (moveAccept || moveReject) a = 1;
    end
    moveValid = 1'b0;
    n_total++; if (a !== 0 || gBoard !== exp_b) $display("FAIL done_ignores_move got pulse=%0d board=%h want 0/%h", a, gBoard, exp_b); else n_pass++;
    n_total++; if ({gameIsDone, winner, moveReady} !== 4'b1110) $display("FAIL done_held got %b want 1110", {gameIsDone, winner, moveReady}); else n_pass++;
  endtask

  task automatic test_diag_win_p2();
    int a, r, c;
    pulse_new_game();
    do_move(4'd0, 2'b11, a, r, c);
    do_move(4'd2, 2'b10, a, r, c);
    do_move(4'd1, 2'b11, a, r, c);
    do_move(4'd4, 2'b10, a, r, c);
    do_move(4'd8, 2'b11, a, r, c);
    n_total++; if (gameIsDone !== 1'b0) $display("FAIL diag_premature got %b want 0", gameIsDone); else n_pass++;
    do_move(4'd6, 2'b10, a, r, c);
    n_total++; if (c !== 11) $display("FAIL diag_win_latency got %0d want 11", c); else n_pass++;
    n_total++; if ({gameIsDone, winner} !== 3'b110) $display("FAIL diag_win_result got %b want 110", {gameIsDone, winner}); else n_pass++;
  endtask

  task automatic test_tie_and_new_game();
    int a, r, c, n_acc;
    logic [3:0] addrs [9];
    addrs = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd3, 4'd5, 4'd7, 4'd6, 4'd8};
    pulse_new_game();
    n_acc = 0;
    for (int m = 0; m < 9; m++) begin
      do_move(addrs[m], (m % 2 == 0) ? 2'b11 : 2'b10, a, r, c);
      if (a == 2) n_acc++;
    end
    n_total++; if (n_acc !== 9) $display("FAIL tie_accepts got %0d want 9", n_acc); else n_pass++;
    n_total++; if (c !== 11) $display("FAIL tie_latency got %0d want 11", c); else n_pass++;
    n_total++; if ({gameIsDone, winner} !== 3'b101) $display("FAIL tie_result got %b want 101", {gameIsDone, winner}); else n_pass++;
    n_total++; if (gBoard !== 18'b11_11_10_10_10_11_11_10_11) $display("FAIL tie_board got %b", gBoard); else n_pass++;
    newGame = 1'b1; moveValid = 1'b1; moveAddr = 4'd0; movePlayer = 2'b11;
    step();
    newGame = 1'b0; moveValid = 1'b0;
    n_total++; if ({moveReady, gameIsDone, winner} !== 4'b1000 || gBoard !== 18'd0) $display("FAIL newgame_clear got %b board=%h want 1000/0", {moveReady, gameIsDone, winner}, gBoard); else n_pass++;
    step();
    n_total++; if (moveReady !== 1'b1) $display("FAIL newgame_drops_move got ready=%b want 1", moveReady); else n_pass++;
  endtask

  task automatic test_reset_mid_scan();
    int a, r, c;
    moveValid = 1'b1; moveAddr = 4'd0; movePlayer = 2'b11;
    step();
    moveValid = 1'b0;
    repeat (4) step();
    n_total++; if (moveReady !== 1'b0 || gBoard[1:0] !== 2'b11) $display("FAIL midscan_precond got ready=%b cell0=%b want 0/11", moveReady, gBoard[1:0]); else n_pass++;
    reset = 1'b1;
    #1;
    n_total++; if (moveReady !== 1'b1 || gBoard !== 18'd0) $display("FAIL async_reset got ready=%b board=%h want 1/0", moveReady, gBoard); else n_pass++;
    n_total++; if ({moveAccept, moveReject, gameIsDone, winner} !== 5'b0) $display("FAIL async_reset_flags got %b want 00000", {moveAccept, moveReject, gameIsDone, winner}); else n_pass++;
    reset = 1'b0;
    step();
    do_move(4'd8, 2'b10, a, r, c);
    n_total++; if (a !== 2 || c !== 11 || gBoard[17:16] !== 2'b10) $display("FAIL post_reset_move got acc=%0d cyc=%0d cell8=%b want 2/11/10", a, c, gBoard[17:16]); else n_pass++;
  endtask

  initial begin
    reset = 1'b1;
    newGame = 1'b0;
    moveValid = 1'b0;
    moveAddr = 4'd0;
    movePlayer = 2'b00;
    test_reset();
    test_first_move();
    test_rejects();
    test_row_win();
    test_diag_win_p2();
    test_tie_and_new_game();
    test_reset_mid_scan();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
